mul_div_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO result registers; executes MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the EX stage of the 5-stage pipeline.
- Data width is parametrised. Runs multi-cycle with a start/busy/done handshake and a flush input.
- The hazard unit uses `busy` to stall MFHI/MFLO and new mul/div issue.

---
 rtl/mul_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative multiply/divide unit with HI/LO result registers.
//             Executes MULT, MULTU, DIV, DIVU (multi-cycle) and MTHI, MTLO
//             (single-edge writes) beside the ALU in the EX stage.
//  Ports    : clk          - clock, rising edge
//             rst          - synchronous reset, active low
//             start        - issue request, sampled only while idle
//             op[2:0]      - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                            100 MTHI, 101 MTLO, 110/111 no-op
//             a, b         - rs / rt operands
//             flush        - abort the operation in flight
//             busy         - multi-cycle operation in flight
//             done         - one-cycle pulse, HI/LO hold the new result
//             div_by_zero  - pulses with done for a divide with b == 0
//             hi, lo       - HI / LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int               CNT_W      = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_RUN  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t             r_state;
   logic               r_is_div;
   logic               r_is_signed;
   logic               r_neg_q;      // product / quotient must be negated
   logic               r_neg_r;      // remainder must be negated
   logic               r_dz;         // divide with zero divisor
   logic [WIDTH-1:0]   r_a;          // raw dividend, kept for the b == 0 result
   logic [WIDTH-1:0]   r_b;          // raw b until PREP, then its magnitude
   logic [2*WIDTH-1:0] r_acc;        // mult: {partial, multiplier}; div: {rem, quo}
   logic [CNT_W-1:0]   r_cnt;

   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_add;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_fits;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   // Magnitudes; the most negative value maps onto itself, which read as an
   // unsigned number is exactly its magnitude.
   assign w_mag_a = (r_is_signed && r_a[WIDTH-1]) ? -r_a : r_a;
   assign w_mag_b = (r_is_signed && r_b[WIDTH-1]) ? -r_b : r_b;

   // Radix-2 shift-add: conditionally add the multiplicand into the upper
   // half, then shift the whole accumulator right, carry included.
   assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
   assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

   // Restoring division: shift the next dividend bit into the remainder and
   // keep the difference only if it did not go negative.
   assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_diff     = w_shift - {1'b0, r_b};
   assign w_fits     = ~w_diff[WIDTH];
   assign w_div_next = {(w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_fits};

   // Sign correction applied in FIX.
   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_is_div    <= 1'b0;
         r_is_signed <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_dz        <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && !flush) begin
                  if (!op[2]) begin
                     r_a         <= a;
                     r_b         <= b;
                     r_is_div    <= op[1];
                     r_is_signed <= ~op[0];
                     busy        <= 1'b1;
                     r_state     <= S_PREP;
                  end else if (op[1:0] == 2'b00) begin
                     hi <= a;
                  end else if (op[1:0] == 2'b01) begin
                     lo <= a;
                  end
               end
            end
            S_PREP: begin
               if (flush) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                  r_b     <= w_mag_b;
                  r_neg_q <= r_is_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                  r_neg_r <= r_is_signed & r_a[WIDTH-1];
                  r_dz    <= r_is_div & (r_b == {WIDTH{1'b0}});
                  r_cnt   <= C_CNT_LOAD;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (flush) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == C_CNT_LAST) begin
                     r_state <= S_FIX;
                  end
               end
            end
            S_FIX: begin
               if (flush) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  if (r_dz) begin
                     hi <= r_a;
                     lo <= {WIDTH{1'b1}};
                  end else if (r_is_div) begin
                     hi <= w_rem;
                     lo <= w_quo;
                  end else begin
                     hi <= w_prod[2*WIDTH-1:WIDTH];
                     lo <= w_prod[WIDTH-1:0];
                  end
                  done        <= 1'b1;
                  div_by_zero <= r_dz;
                  busy        <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Self-checking bench for mul_div_unit (WIDTH = 32). A cycle-level
//             arithmetic model predicts busy/done/div_by_zero/hi/lo and is
//             compared with the DUT every cycle; directed vectors carry
//             hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

   localparam int         W        = 32;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_NOP   = 3'b110;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         flush;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of a mul/div operation: {div_by_zero, hi, lo}.
   function automatic logic [2*W:0] calc(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
      longint          sx, sy, sq, sr;
      longint unsigned up;
      logic [63:0]     v;
      logic [W-1:0]    q, r;
      calc = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         OP_MULT: begin
            v = sx * sy;
            calc = {1'b0, v};
         end
         OP_MULTU: begin
            up = {32'b0, x} * {32'b0, y};
            v = up;
            calc = {1'b0, v};
         end
         OP_DIV: begin
            if (y == 0) calc = {1'b1, x, {W{1'b1}}};
            else begin
               sq = sx / sy;
               sr = sx % sy;
               v = sq; q = v[W-1:0];
               v = sr; r = v[W-1:0];
               calc = {1'b0, r, q};
            end
         end
         OP_DIVU: begin
            if (y == 0) calc = {1'b1, x, {W{1'b1}}};
            else calc = {1'b0, x % y, x / y};
         end
         default: calc = '0;
      endcase
   endfunction

   // Cycle-level expectation: an operation accepted at an edge completes
   // WIDTH+2 edges later unless flushed or reset first.
   logic         m_busy, m_done, m_dz;
   logic [W-1:0] m_hi, m_lo;
   logic [2*W:0] m_res;
   int           m_left;

   always @(posedge clk) begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (!rst) begin
         m_busy = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
      end else if (m_busy) begin
         if (flush) begin
            m_busy = 1'b0; m_left = 0;
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               {m_dz, m_hi, m_lo} = m_res;
            end
         end
      end else if (start && !flush) begin
         if (op <= OP_DIVU) begin
            m_res  = calc(op, a, b);
            m_busy = 1'b1;
            m_left = W + 2;
         end else if (op == OP_MTHI) m_hi = a;
         else if (op == OP_MTLO) m_lo = a;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 64'(busy), 64'(m_busy));
         check("done", 64'(done), 64'(m_done));
         check("div_by_zero", 64'(div_by_zero), 64'(m_dz));
         check("hi", 64'(hi), 64'(m_hi));
         check("lo", 64'(lo), 64'(m_lo));
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = OP_NOP; a = $urandom; b = $urandom;
   endtask

   // lat counts negedges after the accepting edge up to the one where done
   // is seen; done after edge E+34 is seen at the 35th negedge.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
      end
   endtask

   task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                      input logic edz);
      int lat;
      issue(o, x, y);
      wait_done(lat);
      check({name, " latency"}, 64'(lat), 64'(W + 3));
      check({name, " hi"}, 64'(hi), 64'(ehi));
      check({name, " lo"}, 64'(lo), 64'(elo));
      check({name, " dz"}, 64'(div_by_zero), 64'(edz));
      check({name, " model hi"}, 64'(m_hi), 64'(ehi));
      check({name, " model lo"}, 64'(m_lo), 64'(elo));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;
      rst = 1'b0; start = 1'b0; flush = 1'b0; op = OP_NOP; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("reset hi", 64'(hi), 64'h0);
      check("reset lo", 64'(lo), 64'h0);
      check("reset busy", 64'(busy), 64'h0);
      rst = 1'b1;
      @(negedge clk);

      run("mult -3*7",   OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      run("multu max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run("div -7/2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run("div 7/-2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      run("divu 7/2",    OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0);
      run("div min/-1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0);
      run("div -5/0",    OP_DIV,   32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
      run("divu 5/0",    OP_DIVU,  32'd5,        32'h0,        32'd5,        32'hFFFFFFFF, 1'b1);
      @(negedge clk);
      check("dz one cycle", 64'(div_by_zero), 64'h0);
      run("mult 2*3",    OP_MULT,  32'd2,        32'd3,        32'd0,        32'd6,        1'b0);

      // Ignored start mid-run, then flush.
      issue(OP_MULT, 32'd5, 32'd9);
      repeat (5) @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'h0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("flush no done", 64'(seen), 64'h0);
      check("flush hi kept", 64'(hi), 64'd0);
      check("flush lo kept", 64'(lo), 64'd6);

      // MTHI while idle.
      start = 1'b1; op = OP_MTHI; a = 32'h1234;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      check("mthi hi", 64'(hi), 64'h1234);
      check("mthi busy", 64'(busy), 64'h0);
      check("mthi done", 64'(done), 64'h0);

      // Flush wins over an idle MTLO; no-op codes change nothing.
      start = 1'b1; flush = 1'b1; op = OP_MTLO; a = 32'h5555;
      @(negedge clk);
      flush = 1'b0; op = 3'b111;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      check("flushed mtlo lo", 64'(lo), 64'd6);
      check("nop busy", 64'(busy), 64'h0);

      // MTLO while busy is ignored, then a back-to-back start in the done cycle.
      issue(OP_MULT, 32'd4, 32'd5);
      repeat (3) @(negedge clk);
      start = 1'b1; op = OP_MTLO; a = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      check("busy mtlo lo", 64'(lo), 64'd6);
      wait_done(lat);
      check("mult 4*5 lo", 64'(lo), 64'd20);
      issue(OP_MULTU, 32'd3, 32'd3);
      check("b2b busy", 64'(busy), 64'h1);
      wait_done(lat);
      check("b2b latency", 64'(lat), 64'(W + 3));
      check("b2b lo", 64'(lo), 64'd9);

      // Reset in the middle of RUN.
      issue(OP_MULT, 32'd100, 32'd200);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("midrun reset hi", 64'(hi), 64'h0);
      check("midrun reset lo", 64'(lo), 64'h0);
      check("midrun reset busy", 64'(busy), 64'h0);
      check("midrun reset done", 64'(done), 64'h0);
      rst = 1'b1;
      @(negedge clk);
      run("multu 2^16sq", OP_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 1'b0);
      run("divu big",     OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5, 32'h19999999, 1'b0);
      repeat (3) @(negedge clk);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
